// File: rtl/rv32_d_imm_pack.sv
`timescale 1ns/1ps
// rv32_d_imm_pack: scatters an immediate into the RV32 instruction fields (inverse of the decode
// extender) behind a two-stage valid/ready pipeline, with saturating ok/error transfer counters.
module rv32_d_imm_pack #(
   parameter int unsigned CNT_W       = 16,
   parameter bit          ZERO_ON_ERR = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       imm_src_i,
   input  logic [31:0]      imm_i,
   input  logic [31:0]      base_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [31:0]      instr_o,
   output logic             err_o,
   input  logic             clear_i,
   output logic [CNT_W-1:0] cnt_ok_o,
   output logic [CNT_W-1:0] cnt_err_o
);

   localparam logic [2:0] SRC_I   = 3'b000;
   localparam logic [2:0] SRC_S   = 3'b001;
   localparam logic [2:0] SRC_B   = 3'b010;
   localparam logic [2:0] SRC_J   = 3'b011;
   localparam logic [2:0] SRC_U   = 3'b100;
   localparam logic [2:0] SRC_SYS = 3'b101;

   logic             w_s2_rdy;
   logic             w_xfer;
   logic             w_err_in;
   logic [31:0]      w_imm_pk;
   logic [31:0]      w_instr_pk;

   logic             r_s1_v;
   logic             r_s1_err;
   logic [2:0]       r_s1_src;
   logic [31:0]      r_s1_imm;
   logic [31:0]      r_s1_base;
   logic             r_s2_v;
   logic             r_err;
   logic [31:0]      r_instr;
   logic [CNT_W-1:0] r_cnt_ok;
   logic [CNT_W-1:0] r_cnt_err;

   assign w_s2_rdy = !r_s2_v || ready_i;
   assign ready_o  = !r_s1_v || w_s2_rdy;
   assign w_xfer   = r_s2_v && ready_i;

   // Representability: the bits above the format's sign bit must all replicate it.
   always_comb begin
      w_err_in = 1'b1;
      case (imm_src_i)
         SRC_I, SRC_S: w_err_in = (imm_i[31:11] != {21{imm_i[11]}});
         SRC_B:        w_err_in = imm_i[0] || (imm_i[31:12] != {20{imm_i[12]}});
         SRC_J:        w_err_in = imm_i[0] || (imm_i[31:20] != {12{imm_i[20]}});
         SRC_U:        w_err_in = (imm_i[11:0] != 12'h000);
         SRC_SYS:      w_err_in = (imm_i[31:12] != 20'h00000);
         default:      w_err_in = 1'b1;
      endcase
   end

   assign w_imm_pk = (r_s1_err && ZERO_ON_ERR) ? 32'h0000_0000 : r_s1_imm;

   always_comb begin
      w_instr_pk = r_s1_base;
      case (r_s1_src)
         SRC_I, SRC_SYS: w_instr_pk[31:20] = w_imm_pk[11:0];
         SRC_S: begin
            w_instr_pk[31:25] = w_imm_pk[11:5];
            w_instr_pk[11:7]  = w_imm_pk[4:0];
         end
         SRC_B: begin
            w_instr_pk[31]    = w_imm_pk[12];
            w_instr_pk[7]     = w_imm_pk[11];
            w_instr_pk[30:25] = w_imm_pk[10:5];
            w_instr_pk[11:8]  = w_imm_pk[4:1];
         end
         SRC_J: begin
            w_instr_pk[31]    = w_imm_pk[20];
            w_instr_pk[19:12] = w_imm_pk[19:12];
            w_instr_pk[20]    = w_imm_pk[11];
            w_instr_pk[30:21] = w_imm_pk[10:1];
         end
         SRC_U:   w_instr_pk[31:12] = w_imm_pk[31:12];
         default: ;
      endcase
   end

   // NOTE: payload registers carry no reset; they are only observed while their valid bit is set.
   always_ff @(posedge clk_i) begin
      if (valid_i && ready_o) begin
         r_s1_src  <= imm_src_i;
         r_s1_imm  <= imm_i;
         r_s1_base <= base_i;
         r_s1_err  <= w_err_in;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_s1_v  <= 1'b0;
         r_s2_v  <= 1'b0;
         r_instr <= 32'h0000_0000;
         r_err   <= 1'b0;
      end else begin
         if (ready_o) r_s1_v <= valid_i;
         if (w_s2_rdy) r_s2_v <= r_s1_v;
         if (r_s1_v && w_s2_rdy) begin
            r_instr <= w_instr_pk;
            r_err   <= r_s1_err;
         end
      end
   end

   // Clear has priority over a same-cycle increment; both counters stick at all-ones.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         r_cnt_ok  <= '0;
         r_cnt_err <= '0;
      end else if (w_xfer) begin
         if (r_err) begin
            if (r_cnt_err != '1) r_cnt_err <= r_cnt_err + CNT_W'(1);
         end else begin
            if (r_cnt_ok != '1) r_cnt_ok <= r_cnt_ok + CNT_W'(1);
         end
      end
   end

   assign valid_o   = r_s2_v;
   assign instr_o   = r_instr;
   assign err_o     = r_err;
   assign cnt_ok_o  = r_cnt_ok;
   assign cnt_err_o = r_cnt_err;

endmodule
